pc_sequencer: RTL and testbench

Fetch-side PC controller for the RV32 core. It owns the architectural fetch PC, drives the instruction-memory request handshake, and buffers one fetched instruction so decode back-pressure never drops a response. It also consumes the branch unit's resolved next-PC and redirects fetch, flushing younger instructions on a mispredict. Fetch is statically predicted not-taken.

---
 rtl/pc_sequencer_if.sv | 23 ++
 rtl/pc_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch channel between the PC sequencer and instruction memory.
// A transfer happens on any cycle where if_req and if_ack are both high;
// if_rdata is valid in that same cycle.
interface pc_sequencer_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;

   modport master (
      output if_req,
      output if_addr,
      input  if_ack,
      input  if_rdata
   );

   modport slave (
      input  if_req,
      input  if_addr,
      output if_ack,
      output if_rdata
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: owns the fetch PC, issues instruction-memory
// requests, buffers one response against decode stall, and redirects fetch
// when the branch unit reports a next-PC other than the fall-through.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   pc_sequencer_if.master imem,
   output logic          id_valid,
   output logic [31:0]   id_pc,
   output logic [31:0]   id_instr,
   input  logic          br_valid,
   input  logic [31:0]   br_pc,
   input  logic [31:0]   br_next_pc,
   output logic          flush,
   output logic          misalign,
   output logic [31:0]   mispred_cnt
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic        hb_valid_q, hb_valid_d;
   logic [31:0] hb_pc_q, hb_pc_d;
   logic [31:0] hb_instr_q, hb_instr_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        flush_q, flush_d;
   logic        misalign_q, misalign_d;
   logic [31:0] cnt_q, cnt_d;

   logic        req_s;
   logic [31:0] addr_s;
   logic        xfer_s;
   logic        redirect_s;
   logic        tgt_misalign_s;
   logic [31:0] target_s;

   // A redirect is any resolved next-PC that is not the fall-through address.
   assign redirect_s     = br_valid && (br_next_pc != (br_pc + 32'd4));
   assign tgt_misalign_s = (br_next_pc[1:0] != 2'b00);
   assign target_s       = tgt_misalign_s ? TRAP_VEC : br_next_pc;
   assign xfer_s         = req_s && imem.if_ack;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DRAIN swallows the request left outstanding by a redirect.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:  state_d = ST_RUN;
         ST_RUN: begin
            if (redirect_s && req_s && !imem.if_ack) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (imem.if_ack) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default:  state_d = ST_BOOT;
      endcase
   end

   // Fetch request outputs; a full hold buffer suppresses new requests.
   always_comb begin
      req_s  = 1'b0;
      addr_s = pc_q;
      case (state_q)
         ST_BOOT: begin
            req_s  = 1'b0;
            addr_s = pc_q;
         end
         ST_RUN: begin
            req_s  = !hb_valid_q;
            addr_s = pc_q;
         end
         ST_DRAIN: begin
            req_s  = 1'b1;
            addr_s = drain_addr_q;
         end
         default: begin
            req_s  = 1'b0;
            addr_s = pc_q;
         end
      endcase
   end

   // Datapath next-state: redirect overrides stall, transfers and hold-buffer drain.
   always_comb begin
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      hb_valid_d   = hb_valid_q;
      hb_pc_d      = hb_pc_q;
      hb_instr_d   = hb_instr_q;
      id_valid_d   = id_valid_q;
      id_pc_d      = id_pc_q;
      id_instr_d   = id_instr_q;
      flush_d      = 1'b0;
      misalign_d   = 1'b0;
      cnt_d        = cnt_q;
      if (redirect_s) begin
         pc_d       = target_s;
         hb_valid_d = 1'b0;
         id_valid_d = 1'b0;
         flush_d    = 1'b1;
         misalign_d = tgt_misalign_s;
         cnt_d      = cnt_q + 32'd1;
         if ((state_q == ST_RUN) && req_s && !imem.if_ack) begin
            drain_addr_d = addr_s;
         end else begin
            drain_addr_d = drain_addr_q;
         end
      end else if (xfer_s && (state_q == ST_RUN)) begin
         pc_d = pc_q + 32'd4;
         if (!stall && !hb_valid_q) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = imem.if_rdata;
         end else begin
            hb_valid_d = 1'b1;
            hb_pc_d    = pc_q;
            hb_instr_d = imem.if_rdata;
         end
      end else if (!stall && hb_valid_q) begin
         id_valid_d = 1'b1;
         id_pc_d    = hb_pc_q;
         id_instr_d = hb_instr_q;
         hb_valid_d = 1'b0;
      end else if (!stall) begin
         // Decode took the last instruction and nothing new arrived.
         id_valid_d = 1'b0;
      end else begin
         id_valid_d = id_valid_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         hb_valid_q   <= 1'b0;
         hb_pc_q      <= 32'h0000_0000;
         hb_instr_q   <= NOP;
         id_valid_q   <= 1'b0;
         id_pc_q      <= 32'h0000_0000;
         id_instr_q   <= NOP;
         flush_q      <= 1'b0;
         misalign_q   <= 1'b0;
         cnt_q        <= 32'h0000_0000;
      end else begin
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         hb_valid_q   <= hb_valid_d;
         hb_pc_q      <= hb_pc_d;
         hb_instr_q   <= hb_instr_d;
         id_valid_q   <= id_valid_d;
         id_pc_q      <= id_pc_d;
         id_instr_q   <= id_instr_d;
         flush_q      <= flush_d;
         misalign_q   <= misalign_d;
         cnt_q        <= cnt_d;
      end
   end

   assign imem.if_req  = req_s;
   assign imem.if_addr = addr_s;
   assign id_valid     = id_valid_q;
   assign id_pc        = id_pc_q;
   assign id_instr     = id_instr_q;
   assign flush        = flush_q;
   assign misalign     = misalign_q;
   assign mispred_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed stimulus with literal expectations plus a
// program-order model that checks every cycle after reset.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        br_valid = 1'b0;
   logic [31:0] br_pc = 32'h0;
   logic [31:0] br_next_pc = 32'h0;
   logic        id_valid, flush, misalign;
   logic [31:0] id_pc, id_instr, mispred_cnt;

   int n_vec = 0;
   int n_err = 0;

   pc_sequencer_if imem_bus();

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_bus.if_rdata = mem_f(imem_bus.if_addr);

   pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .imem       (imem_bus),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_instr   (id_instr),
      .br_valid   (br_valid),
      .br_pc      (br_pc),
      .br_next_pc (br_next_pc),
      .flush      (flush),
      .misalign   (misalign),
      .mispred_cnt(mispred_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_values();
      chk1("rst_if_req", imem_bus.if_req, 1'b0);
      chk("rst_if_addr", imem_bus.if_addr, RESET_PC);
      chk1("rst_id_valid", id_valid, 1'b0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, NOP);
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_misalign", misalign, 1'b0);
      chk("rst_cnt", mispred_cnt, 32'h0);
   endtask

   // Model: program-order PC stream seen by decode, fetch address stream,
   // redirect-driven pulses and counter, request stability and stall hold.
   logic [31:0] m_exp_pc, m_fetch, m_cnt, p_addr, p_idpc, p_idinstr, tgt_now;
   logic        m_discard, p_redir, p_mis, p_stall, p_req, p_ack, p_idv;
   logic        redir_now, xfer_now;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_exp_pc  = RESET_PC;
         m_fetch   = RESET_PC;
         m_cnt     = 32'h0;
         m_discard = 1'b0;
         p_redir   = 1'b0;
         p_mis     = 1'b0;
         p_stall   = 1'b0;
         p_req     = 1'b0;
         p_ack     = 1'b0;
         p_idv     = 1'b0;
         p_addr    = 32'h0;
         p_idpc    = 32'h0;
         p_idinstr = NOP;
      end else begin
         chk1("m_flush", flush, p_redir);
         chk1("m_misalign", misalign, p_redir && p_mis);
         chk("m_cnt", mispred_cnt, m_cnt);
         if (p_redir) begin
            chk1("m_id_killed", id_valid, 1'b0);
         end
         if (p_stall && !p_redir) begin
            chk1("m_hold_valid", id_valid, p_idv);
            chk("m_hold_pc", id_pc, p_idpc);
            chk("m_hold_instr", id_instr, p_idinstr);
         end
         if (p_req && !p_ack) begin
            chk1("m_req_kept", imem_bus.if_req, 1'b1);
            chk("m_addr_kept", imem_bus.if_addr, p_addr);
         end
         redir_now = br_valid && (br_next_pc != (br_pc + 32'd4));
         tgt_now   = (br_next_pc[1:0] != 2'b00) ? TRAP_VEC : br_next_pc;
         xfer_now  = imem_bus.if_req && imem_bus.if_ack;
         if (xfer_now) begin
            if (m_discard) begin
               m_discard = 1'b0;
            end else begin
               chk("m_fetch_addr", imem_bus.if_addr, m_fetch);
               m_fetch = m_fetch + 32'd4;
            end
         end
         if (id_valid && !stall && !redir_now) begin
            chk("m_id_pc_order", id_pc, m_exp_pc);
            chk("m_id_instr", id_instr, mem_f(id_pc));
            m_exp_pc = m_exp_pc + 32'd4;
         end
         if (redir_now) begin
            m_exp_pc = tgt_now;
            m_fetch  = tgt_now;
            m_cnt    = m_cnt + 32'd1;
            if (imem_bus.if_req && !imem_bus.if_ack) begin
               m_discard = 1'b1;
            end
         end
         p_redir   = redir_now;
         p_mis     = (br_next_pc[1:0] != 2'b00);
         p_stall   = stall;
         p_req     = imem_bus.if_req;
         p_ack     = imem_bus.if_ack;
         p_addr    = imem_bus.if_addr;
         p_idv     = id_valid;
         p_idpc    = id_pc;
         p_idinstr = id_instr;
      end
   end

   // Directed scenarios with hand-computed expectations.
   initial begin
      imem_bus.if_ack = 1'b1;
      step(2);
      chk_reset_values();
      rst_n = 1'b1;
      chk1("boot_no_req", imem_bus.if_req, 1'b0);
      step(1);
      chk1("first_req", imem_bus.if_req, 1'b1);
      chk("first_addr", imem_bus.if_addr, 32'h0);
      chk1("first_idv", id_valid, 1'b0);
      step(1);
      chk("stream_addr4", imem_bus.if_addr, 32'h4);
      chk1("stream_idv0", id_valid, 1'b1);
      chk("stream_idpc0", id_pc, 32'h0);
      chk("stream_instr0", id_instr, 32'hA5A5_0000);
      step(1);
      chk("stream_addr8", imem_bus.if_addr, 32'h8);
      chk("stream_idpc4", id_pc, 32'h4);
      step(1);
      chk("stream_addrc", imem_bus.if_addr, 32'hC);
      chk("stream_idpc8", id_pc, 32'h8);
      step(1);
      chk("stream_addr10", imem_bus.if_addr, 32'h10);
      chk("stream_idpcc", id_pc, 32'hC);

      // Three-cycle stall: one response lands in the hold buffer.
      stall = 1'b1;
      step(1);
      chk1("stall_req_drop", imem_bus.if_req, 1'b0);
      chk("stall_hold_pc1", id_pc, 32'hC);
      step(1);
      chk1("stall_req_drop2", imem_bus.if_req, 1'b0);
      step(1);
      chk("stall_hold_pc3", id_pc, 32'hC);
      stall = 1'b0;
      step(1);
      chk("unstall_hb_pc", id_pc, 32'h10);
      chk("unstall_hb_instr", id_instr, 32'hA5A5_0010);
      chk("unstall_addr", imem_bus.if_addr, 32'h14);
      step(1);
      chk("unstall_next_pc", id_pc, 32'h14);
      chk("unstall_next_addr", imem_bus.if_addr, 32'h18);

      // Redirect with a same-cycle ack.
      br_valid = 1'b1; br_pc = 32'h10; br_next_pc = 32'h40;
      step(1);
      br_valid = 1'b0;
      chk1("redir_flush", flush, 1'b1);
      chk1("redir_idv", id_valid, 1'b0);
      chk("redir_addr", imem_bus.if_addr, 32'h40);
      chk("redir_cnt", mispred_cnt, 32'd1);
      chk1("redir_no_mis", misalign, 1'b0);
      step(1);
      chk1("redir_flush_off", flush, 1'b0);
      chk("redir_id_pc", id_pc, 32'h40);
      chk("redir_id_instr", id_instr, 32'hA5A5_0040);

      // Redirect to 0x80 while a request to 0x20 is pending.
      br_valid = 1'b1; br_pc = 32'h100; br_next_pc = 32'h20;
      step(1);
      br_valid = 1'b0;
      imem_bus.if_ack = 1'b0;
      chk("pend_addr20", imem_bus.if_addr, 32'h20);
      chk("pend_cnt2", mispred_cnt, 32'd2);
      step(1);
      chk1("pend_req", imem_bus.if_req, 1'b1);
      br_valid = 1'b1; br_pc = 32'h200; br_next_pc = 32'h80;
      step(1);
      br_valid = 1'b0;
      chk1("drain_flush", flush, 1'b1);
      chk("drain_addr_a", imem_bus.if_addr, 32'h20);
      chk("drain_cnt3", mispred_cnt, 32'd3);
      step(1);
      chk("drain_addr_b", imem_bus.if_addr, 32'h20);
      imem_bus.if_ack = 1'b1;
      step(1);
      chk("drain_done_addr", imem_bus.if_addr, 32'h80);
      chk1("drain_data_dropped", id_valid, 1'b0);
      step(1);
      chk("drain_target_pc", id_pc, 32'h80);
      chk1("drain_target_idv", id_valid, 1'b1);

      // Misaligned target goes to the trap vector.
      br_valid = 1'b1; br_pc = 32'h300; br_next_pc = 32'h42;
      step(1);
      br_valid = 1'b0;
      chk1("mis_pulse", misalign, 1'b1);
      chk("mis_trap_addr", imem_bus.if_addr, TRAP_VEC);
      chk("mis_cnt4", mispred_cnt, 32'd4);
      step(1);
      chk1("mis_pulse_off", misalign, 1'b0);
      chk("mis_trap_id", id_pc, TRAP_VEC);

      // Correctly predicted branches during stall change nothing.
      stall = 1'b1; br_valid = 1'b1; br_pc = 32'h500; br_next_pc = 32'h504;
      step(1);
      chk1("pred_no_flush", flush, 1'b0);
      chk("pred_id_hold", id_pc, 32'h100);
      chk1("pred_req_drop", imem_bus.if_req, 1'b0);
      br_pc = 32'hFFFF_FFFC; br_next_pc = 32'h0000_0000;
      step(1);
      chk1("pred_wrap_no_flush", flush, 1'b0);
      chk("pred_wrap_cnt", mispred_cnt, 32'd4);
      stall = 1'b0; br_valid = 1'b0;
      step(1);
      chk("pred_release_pc", id_pc, 32'h104);
      chk("pred_release_addr", imem_bus.if_addr, 32'h108);

      // Redirect under stall with a full hold buffer.
      stall = 1'b1;
      step(2);
      chk1("hbfull_req", imem_bus.if_req, 1'b0);
      br_valid = 1'b1; br_pc = 32'h0; br_next_pc = 32'h200;
      step(1);
      br_valid = 1'b0; stall = 1'b0;
      chk1("stallredir_idv", id_valid, 1'b0);
      chk1("stallredir_req", imem_bus.if_req, 1'b1);
      chk("stallredir_addr", imem_bus.if_addr, 32'h200);
      step(1);
      chk("stallredir_id_pc", id_pc, 32'h200);

      // Asynchronous reset while draining.
      imem_bus.if_ack = 1'b0;
      br_valid = 1'b1; br_pc = 32'h0; br_next_pc = 32'h300;
      step(1);
      br_valid = 1'b0;
      chk("mid_drain_cnt", mispred_cnt, 32'd6);
      #2 rst_n = 1'b0;
      #1 chk_reset_values();
      @(posedge clk);
      #1;
      imem_bus.if_ack = 1'b1;
      rst_n = 1'b1;
      chk1("reboot_no_req", imem_bus.if_req, 1'b0);
      step(1);
      chk("reboot_addr", imem_bus.if_addr, RESET_PC);
      step(1);
      chk1("reboot_idv", id_valid, 1'b1);
      chk("reboot_id_pc", id_pc, RESET_PC);
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
